// File: rtl/select_data_wb.sv
// Writeback data selector: picks the AU, MUL or LSU result by a one-hot select.
// It registers the chosen data, destination index, write enable and a multi-hot conflict flag.
module select_data_wb #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       au_result,
  input  logic [XLEN-1:0]       mul_result,
  input  logic [XLEN-1:0]       lsu_result,
  input  logic [2:0]            select,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_en,
  output logic                  sel_conflict
);

  // True when two or more of the three select bits are set.
  function automatic logic multi_hot3(input logic [2:0] sel);
    return (sel[0] & sel[1]) | (sel[0] & sel[2]) | (sel[1] & sel[2]);
  endfunction

  logic [XLEN-1:0]       sel_data_s;
  logic [REG_ADDR_W-1:0] sel_rd_s;
  logic                  sel_en_s;
  logic                  sel_conflict_s;

  // Source choice with fixed priority LSU > MUL > AU; an empty select yields no writeback.
  always_comb begin
    sel_data_s     = {XLEN{1'b0}};
    sel_rd_s       = {REG_ADDR_W{1'b0}};
    sel_en_s       = 1'b0;
    sel_conflict_s = multi_hot3(select);
    if (select[2]) begin
      sel_data_s = lsu_result;
    end else if (select[1]) begin
      sel_data_s = mul_result;
    end else if (select[0]) begin
      sel_data_s = au_result;
    end else begin
      sel_data_s = {XLEN{1'b0}};
    end
    // x0 writes keep data and index visible but never assert the write enable.
    if (select != 3'b000) begin
      sel_rd_s = rd_in;
      sel_en_s = (rd_in != {REG_ADDR_W{1'b0}});
    end else begin
      sel_rd_s = {REG_ADDR_W{1'b0}};
      sel_en_s = 1'b0;
    end
  end

  // Output register; reset overrides any select value.
  always_ff @(posedge clk) begin
    if (rst) begin
      result       <= {XLEN{1'b0}};
      wb_rd        <= {REG_ADDR_W{1'b0}};
      wb_en        <= 1'b0;
      sel_conflict <= 1'b0;
    end else begin
      result       <= sel_data_s;
      wb_rd        <= sel_rd_s;
      wb_en        <= sel_en_s;
      sel_conflict <= sel_conflict_s;
    end
  end

endmodule

// File: tb/tb_select_data_wb.sv
// Directed self-checking bench for select_data_wb.
// Inputs change 1 time unit after a rising edge; outputs are checked after the next edge.
module tb_select_data_wb;

  logic        clk;
  logic        rst;
  logic [31:0] au_result;
  logic [31:0] mul_result;
  logic [31:0] lsu_result;
  logic [2:0]  select;
  logic [4:0]  rd_in;
  logic [31:0] result;
  logic [4:0]  wb_rd;
  logic        wb_en;
  logic        sel_conflict;

  int n_checks;
  int n_fail;

  select_data_wb #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .au_result    (au_result),
    .mul_result   (mul_result),
    .lsu_result   (lsu_result),
    .select       (select),
    .rd_in        (rd_in),
    .result       (result),
    .wb_rd        (wb_rd),
    .wb_en        (wb_en),
    .sel_conflict (sel_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_res, input logic [4:0] e_rd,
                           input logic e_en, input logic e_conf);
    check({tag, ".result"}, result, e_res);
    check({tag, ".wb_rd"}, 32'(wb_rd), 32'(e_rd));
    check({tag, ".wb_en"}, 32'(wb_en), 32'(e_en));
    check({tag, ".conflict"}, 32'(sel_conflict), 32'(e_conf));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset held two edges with a live AU selection
    rst = 1'b1; select = 3'b001; au_result = 32'hDEADBEEF;
    mul_result = 32'h0; lsu_result = 32'h0; rd_in = 5'd5;
    tick(); check_all("rst1", 32'h0, 5'd0, 1'b0, 1'b0);
    tick(); check_all("rst2", 32'h0, 5'd0, 1'b0, 1'b0);

    // Single sources back to back
    rst = 1'b0;
    au_result = 32'h11111111; mul_result = 32'h22222222; lsu_result = 32'h33333333;
    rd_in = 5'd5; select = 3'b001;
    tick(); check_all("au", 32'h11111111, 5'd5, 1'b1, 1'b0);
    select = 3'b010;
    tick(); check_all("mul", 32'h22222222, 5'd5, 1'b1, 1'b0);
    select = 3'b100;
    tick(); check_all("lsu", 32'h33333333, 5'd5, 1'b1, 1'b0);

    // No writeback
    select = 3'b000; rd_in = 5'd7;
    tick(); check_all("none", 32'h0, 5'd0, 1'b0, 1'b0);

    // x0 suppression
    select = 3'b010; mul_result = 32'hCAFEF00D; rd_in = 5'd0;
    tick(); check_all("x0", 32'hCAFEF00D, 5'd0, 1'b0, 1'b0);

    // Conflict priority
    mul_result = 32'h22222222; rd_in = 5'd3; select = 3'b111;
    tick(); check_all("c111", 32'h33333333, 5'd3, 1'b1, 1'b1);
    select = 3'b011;
    tick(); check_all("c011", 32'h22222222, 5'd3, 1'b1, 1'b1);
    select = 3'b101;
    tick(); check_all("c101", 32'h33333333, 5'd3, 1'b1, 1'b1);
    select = 3'b110; rd_in = 5'd0;
    tick(); check_all("c110x0", 32'h33333333, 5'd0, 1'b0, 1'b1);

    // Input changes between edges must not reach the outputs
    select = 3'b001; rd_in = 5'd31; au_result = 32'hA5A5A5A5;
    tick(); check_all("pre", 32'hA5A5A5A5, 5'd31, 1'b1, 1'b0);
    #1; select = 3'b110; rd_in = 5'd1; au_result = 32'h0F0F0F0F;
    #1; check_all("hold", 32'hA5A5A5A5, 5'd31, 1'b1, 1'b0);

    // Mid-stream reset
    select = 3'b001; rd_in = 5'd9; au_result = 32'h12345678;
    tick(); check_all("pre_rst", 32'h12345678, 5'd9, 1'b1, 1'b0);
    rst = 1'b1; select = 3'b010; mul_result = 32'h87654321;
    tick(); check_all("mid_rst", 32'h0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0; select = 3'b100; lsu_result = 32'hFFFFFFFF; rd_in = 5'd10;
    tick(); check_all("post_rst", 32'hFFFFFFFF, 5'd10, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
